// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_ctrl
// Brief    : Commit-stage MIPS CP0: BadVAddr/Count/Compare/Status/Cause/EPC,
//            interrupt > exception > ERET arbitration, same-cycle flush.
//            Timer (Count/Compare/prescaler/TI) present only with CP0_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_ctrl #(
   parameter int          HW_INT_NUM = 6,
   parameter int          TIMER_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [HW_INT_NUM-1:0] hw_int,
   input  logic                  commit_valid,
   input  logic [31:0]           commit_pc,
   input  logic                  commit_in_ds,
   input  logic                  commit_exc,
   input  logic [4:0]            commit_exccode,
   input  logic                  commit_badv_en,
   input  logic [31:0]           commit_badvaddr,
   input  logic                  commit_eret,
   input  logic                  mtc0_wen,
   input  logic [4:0]            mtc0_addr,
   input  logic [31:0]           mtc0_wdata,
   input  logic [4:0]            mfc0_addr,
   output logic [31:0]           mfc0_rdata,
   output logic                  flush,
   output logic [31:0]           flush_pc,
   output logic                  int_pending
);

   localparam logic [4:0] c_reg_badv    = 5'd8;
   localparam logic [4:0] c_reg_count   = 5'd9;
   localparam logic [4:0] c_reg_compare = 5'd11;
   localparam logic [4:0] c_reg_status  = 5'd12;
   localparam logic [4:0] c_reg_cause   = 5'd13;
   localparam logic [4:0] c_reg_epc     = 5'd14;

   generate
      if (HW_INT_NUM < 1 || HW_INT_NUM > 6) begin : g_bad_hw_int_num
         $error("cp0_ctrl: HW_INT_NUM must be 1..6");
      end
      if (TIMER_DIV < 1 || TIMER_DIV > 16) begin : g_bad_timer_div
         $error("cp0_ctrl: TIMER_DIV must be 1..16");
      end
   endgenerate

   logic [31:0]           r_badvaddr;
   logic [31:0]           r_epc;
   logic [7:0]            r_im;
   logic                  r_exl;
   logic                  r_ie;
   logic                  r_bd;
   logic [4:0]            r_exccode;
   logic [1:0]            r_ip_sw;
   logic [HW_INT_NUM-1:0] r_hw;

   logic                  w_ti;
   logic [31:0]           w_count;
   logic [31:0]           w_compare;
   logic [5:0]            w_hw6;
   logic [7:0]            w_ip;
   logic                  w_take_int;
   logic                  w_take_exc;
   logic                  w_take_eret;
   logic                  w_trap;
   logic                  w_wr;

   // Lines beyond HW_INT_NUM read as zero in Cause.IP
   generate
      for (genvar i = 0; i < 6; i++) begin : g_hw_map
         if (i < HW_INT_NUM) begin : g_used
            assign w_hw6[i] = r_hw[i];
         end else begin : g_unused
            assign w_hw6[i] = 1'b0;
         end
      end
   endgenerate

   assign w_ip        = {w_hw6[5] | w_ti, w_hw6[4:0], r_ip_sw};
   assign int_pending = |(w_ip & r_im);

   assign w_take_int  = commit_valid & r_ie & ~r_exl & int_pending;
   assign w_take_exc  = commit_valid & commit_exc & ~w_take_int;
   assign w_take_eret = commit_valid & commit_eret & ~commit_exc & ~w_take_int;
   assign w_trap      = w_take_int | w_take_exc;
   assign flush       = w_trap | w_take_eret;
   assign flush_pc    = w_take_eret ? r_epc : EXC_VECTOR;
   assign w_wr        = mtc0_wen & ~flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_badvaddr <= 32'd0;
         r_epc      <= 32'd0;
         r_im       <= 8'd0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_exccode  <= 5'd0;
         r_ip_sw    <= 2'd0;
         r_hw       <= '0;
      end else begin
         r_hw <= hw_int;
         if (w_trap) begin
            // A nested trap keeps the original return point
            if (!r_exl) begin
               r_epc <= commit_in_ds ? (commit_pc - 32'd4) : commit_pc;
               r_bd  <= commit_in_ds;
            end
            r_exccode <= w_take_int ? 5'd0 : commit_exccode;
            r_exl     <= 1'b1;
            if (w_take_exc && commit_badv_en) begin
               r_badvaddr <= commit_badvaddr;
            end
         end else if (w_take_eret) begin
            r_exl <= 1'b0;
         end else if (w_wr) begin
            if (mtc0_addr == c_reg_status) begin
               r_im  <= mtc0_wdata[15:8];
               r_exl <= mtc0_wdata[1];
               r_ie  <= mtc0_wdata[0];
            end
            if (mtc0_addr == c_reg_cause) begin
               r_ip_sw <= mtc0_wdata[9:8];
            end
            if (mtc0_addr == c_reg_epc) begin
               r_epc <= mtc0_wdata;
            end
            if (mtc0_addr == c_reg_badv) begin
               r_badvaddr <= mtc0_wdata;
            end
         end
      end
   end

`ifdef CP0_TIMER_EN
   localparam int c_presc_w = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TIMER_DIV - 1);

   logic [c_presc_w-1:0] r_presc;
   logic [31:0]          r_count;
   logic [31:0]          r_compare;
   logic                 r_ti;
   logic                 w_wr_count;
   logic                 w_wr_compare;

   assign w_wr_count   = w_wr & (mtc0_addr == c_reg_count);
   assign w_wr_compare = w_wr & (mtc0_addr == c_reg_compare);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc   <= '0;
         r_count   <= 32'd0;
         r_compare <= 32'd0;
         r_ti      <= 1'b0;
      end else begin
         if (w_wr_count) begin
            r_count <= mtc0_wdata;
            r_presc <= '0;
         end else if (r_presc == c_presc_max) begin
            r_presc <= '0;
            r_count <= r_count + 32'd1;
         end else begin
            r_presc <= r_presc + c_presc_w'(1);
         end
         // Writing Compare acknowledges the timer even on a matching cycle
         if (w_wr_compare) begin
            r_compare <= mtc0_wdata;
            r_ti      <= 1'b0;
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign w_ti      = r_ti;
   assign w_count   = r_count;
   assign w_compare = r_compare;
`else
   assign w_ti      = 1'b0;
   assign w_count   = 32'd0;
   assign w_compare = 32'd0;
`endif

   always_comb begin
      mfc0_rdata = 32'd0;
      case (mfc0_addr)
         c_reg_badv:    mfc0_rdata = r_badvaddr;
         c_reg_count:   mfc0_rdata = w_count;
         c_reg_compare: mfc0_rdata = w_compare;
         c_reg_status:  mfc0_rdata = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
         c_reg_cause:   mfc0_rdata = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};
         c_reg_epc:     mfc0_rdata = r_epc;
         default:       mfc0_rdata = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised coprocessor-0 controller for the 32-bit MIPS-subset core, sitting at the commit stage. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and arbitrates interrupts, exceptions and ERET for the committing instruction. It drives a same-cycle pipeline flush with the redirect PC. Unlike the previous controller, it adds:

- a configurable number of external interrupt lines;
- a configurable timer prescaler;
- a sticky, clearable timer interrupt;
- MIPS-correct nested-exception handling (EPC and BD frozen while EXL=1).

## Interface
Parameters:
- HW_INT_NUM, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2 +: HW_INT_NUM]
- TIMER_DIV, 2, clk cycles per Count increment (1..16)
- EXC_VECTOR, 32'hBFC0_0380, exception/interrupt entry PC

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- hw_int  in  HW_INT_NUM  level-sensitive external interrupt requests
- commit_valid  in  1  an instruction commits this cycle
- commit_pc  in  32  PC of the committing instruction
- commit_in_ds  in  1  committing instruction is in a branch delay slot
- commit_exc  in  1  committing instruction raised an exception
- commit_exccode  in  5  ExcCode of that exception
- commit_badv_en  in  1  exception carries a bad address (AdEL/AdES)
- commit_badvaddr  in  32  faulting address
- commit_eret  in  1  committing instruction is ERET
- mtc0_wen  in  1  MTC0 write from the committing instruction
- mtc0_addr  in  5  CP0 register number
- mtc0_wdata  in  32  write data
- mfc0_addr  in  5  read register number
- mfc0_rdata  out  32  combinational read data
- flush  out  1  flush pipeline and redirect this cycle
- flush_pc  out  32  redirect target
- int_pending  out  1  |(Cause.IP & Status.IM), ungated

## Operation
Register map:
- BadVAddr (8)
- Count (9)
- Compare (11)
- Status (12): BEV[22] is read-only 1; IM[15:8], EXL[1] and IE[0] are writable.
- Cause (13): BD[31] and TI[30] are read-only; IP[15:10] are hardware-set; IP[9:8] are software-writable; ExcCode[6:2] is read-only to MTC0.
- EPC (14)
- All other addresses read 0. Writes to them are ignored.

Interrupt-pending logic:
- Cause.IP[2+i] <= hw_int[i] every cycle.
- IP[7] = TI | (HW_INT_NUM==6 ? hw_int[5] : 0).
- Unused IP bits read 0.

Event priority within a commit cycle (all gated by commit_valid):
1. **Interrupt**, when IE & ~EXL & |(IP & IM). ExcCode=0. The instruction's own exception or ERET is discarded.
2. **Exception**, when commit_exc.
3. **ERET**, when commit_eret & ~commit_exc.

On interrupt or exception:
- If EXL was 0: EPC <= commit_in_ds ? commit_pc-4 : commit_pc, and BD <= commit_in_ds.
- If EXL was already 1: EPC and BD are unchanged.
- ExcCode is always updated.
- BadVAddr is written only on an exception with commit_badv_en.
- EXL <= 1.
- flush=1, flush_pc=EXC_VECTOR.

On ERET: EXL <= 0, flush=1, flush_pc=EPC (the current register value).

MTC0 handling:
- mtc0_wen is ignored whenever flush=1.
- Otherwise the write is applied at the clock edge.

Timer:
- A prescaler counts 0..TIMER_DIV-1. Count increments when the prescaler wraps.
- Count wraps 0xFFFF_FFFF -> 0.
- TI is set on any cycle where Count==Compare, and stays set.
- An MTC0 to Compare clears TI. The clear wins over a same-cycle set.
- An MTC0 to Count loads Count, resets the prescaler to 0, and wins over the increment.

## Timing
- Reset values: Status=0x0040_0000; Cause=0; Count=0; prescaler=0; flush=0; int_pending=0; EPC, BadVAddr and Compare=0.
- flush and flush_pc are combinational in the commit cycle. Register updates take effect at the next edge.
- hw_int to IP has 1-cycle latency, so an interrupt can be taken at the earliest 2 edges after hw_int rises.
- mfc0_rdata returns the pre-edge value; there is no same-cycle MTC0 bypass.
- A reset asserted in any cycle overrides all updates in that cycle.

## Configuration
CP0_TIMER_EN:
- **Defined:** Count, Compare, the prescaler and TI are implemented as above.
- **Undefined:** Count and Compare read 0 and ignore writes. TI is constant 0. IP[7] comes only from hw_int[5]. No timer flops are synthesised.

## Test plan
- **Reset, then read:** reset, then MFC0 12 -> 0x0040_0000; MFC0 13 -> 0.
- **Delay-slot exception:** commit_exc=1, exccode=4, badv_en=1, badvaddr=0x1003, pc=0xBFC0_0104, in_ds=1.
  - Same cycle: flush=1, flush_pc=0xBFC0_0380.
  - Next cycle: EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1003, Status.EXL=1.
- **Nested exception:** with EXL=1, commit_exc with exccode=10 at pc=0x200 -> ExcCode=10; EPC unchanged; flush=1.
- **Timer, TIMER_DIV=2 (CP0_TIMER_EN defined):**
  - Write Compare=5, Count=0 -> TI=1 after 10 cycles.
  - With Status=0x0040_8001, the next commit_valid cycle gives flush=1, ExcCode=0.
  - MTC0 Compare clears TI.
- **ERET:** after an exception with EPC=0x80, commit_eret -> flush_pc=0x80; EXL=0 next cycle.
- **Interrupt over exception:** hw_int[0]=1, IE=1, IM[2]=1, commit_exc=1 in the same cycle -> ExcCode=0 (interrupt wins); BadVAddr unchanged.
